// File: rtl/branch_resolve_multi.sv
// Multi-lane branch resolution: resolves each lane, raises a registered flush for the
// oldest mispredict, and queues predictor-training records in a small FIFO.
`ifndef ALU_BEQ
`define ALU_ADD  8'h01
`define ALU_BEQ  8'h50
`define ALU_BNE  8'h51
`define ALU_BLT  8'h52
`define ALU_BGE  8'h53
`define ALU_BLTU 8'h54
`define ALU_BGEU 8'h55
`define ALU_B    8'h56
`define ALU_BL   8'h57
`define ALU_JIRL 8'h58
`endif

module branch_resolve_multi #(
  parameter int LANES     = 2,
  parameter int UPD_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_flush,
  input  logic [LANES-1:0]    in_valid,
  input  logic [32*LANES-1:0] in_pc,
  input  logic [32*LANES-1:0] in_inst,
  input  logic [8*LANES-1:0]  in_aluop,
  input  logic [32*LANES-1:0] in_reg1,
  input  logic [32*LANES-1:0] in_reg2,
  input  logic [LANES-1:0]    in_pre_taken,
  input  logic [32*LANES-1:0] in_pre_addr,
  output logic [LANES-1:0]    out_valid,
  output logic [32*LANES-1:0] out_link,
  output logic                branch_flush,
  output logic [31:0]         flush_target,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [31:0]         upd_pc,
  output logic [31:0]         upd_target,
  output logic                upd_taken,
  output logic [1:0]          upd_kind,
  output logic                upd_drop
);
  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    KIND_COND = 2'd0,
    KIND_B    = 2'd1,
    KIND_BL   = 2'd2,
    KIND_JIRL = 2'd3
  } kind_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
    kind_e       kind;
  } upd_rec_t;

  logic [LANES-1:0] is_br, taken, mispred, lane_ok, push_req, push_acc, unused_inst;
  kind_e            kind    [LANES];
  logic [31:0]      target  [LANES];
  logic [31:0]      link    [LANES];
  logic [31:0]      next_pc [LANES];
  logic [PTR_W-1:0] slot    [LANES];

  upd_rec_t         mem [UPD_DEPTH];
  upd_rec_t         head;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count, cap, n_acc;
  logic             ignore, found, pop, drop;
  logic [31:0]      win_target;

  // Per-lane resolve: direction, target and mispredict against the front-end guess.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      logic [31:0] pc, inst, r1, r2, off16, off26;
      pc    = in_pc[i*32 +: 32];
      inst  = in_inst[i*32 +: 32];
      r1    = in_reg1[i*32 +: 32];
      r2    = in_reg2[i*32 +: 32];
      off16 = {{14{inst[25]}}, inst[25:10], 2'b00};
      off26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
      // NOTE: every output of this block gets a default before the case, so no latch is inferred.
      is_br[i] = 1'b1;
      kind[i]  = KIND_COND;
      taken[i] = 1'b0;
      case (in_aluop[i*8 +: 8])
        `ALU_BEQ:  taken[i] = (r1 == r2);
        `ALU_BNE:  taken[i] = (r1 != r2);
        `ALU_BLT:  taken[i] = ($signed(r1) < $signed(r2));
        `ALU_BGE:  taken[i] = ($signed(r1) >= $signed(r2));
        `ALU_BLTU: taken[i] = (r1 < r2);
        `ALU_BGEU: taken[i] = (r1 >= r2);
        `ALU_B:    begin kind[i] = KIND_B;    taken[i] = 1'b1; end
        `ALU_BL:   begin kind[i] = KIND_BL;   taken[i] = 1'b1; end
        `ALU_JIRL: begin kind[i] = KIND_JIRL; taken[i] = 1'b1; end
        default:   is_br[i] = 1'b0;
      endcase
      case (kind[i])
        KIND_B, KIND_BL: target[i] = pc + off26;
        KIND_JIRL:       target[i] = r1 + off16;
        default:         target[i] = pc + off16;
      endcase
      link[i]    = pc + 32'd4;
      next_pc[i] = taken[i] ? target[i] : link[i];
      mispred[i] = taken[i] ? (!in_pre_taken[i] || (in_pre_addr[i*32 +: 32] != target[i]))
                            : in_pre_taken[i];
      unused_inst[i] = ^inst[31:26];
    end
  end

  assign pop = upd_valid && upd_ready;

  // Oldest mispredict wins and kills younger lanes; surviving pushes take FIFO slots in lane order.
  always_comb begin
    ignore     = branch_flush || ex_flush;
    found      = 1'b0;
    win_target = '0;
    drop       = 1'b0;
    n_acc      = '0;
    cap        = CNT_W'(UPD_DEPTH) - count + CNT_W'(pop);
    for (int i = 0; i < LANES; i++) begin
      lane_ok[i]  = in_valid[i] && !ignore && !found;
      push_req[i] = lane_ok[i] && is_br[i] &&
                    (kind[i] == KIND_COND || kind[i] == KIND_JIRL || mispred[i]);
      push_acc[i] = push_req[i] && (n_acc < cap);
      slot[i]     = wr_ptr + n_acc[PTR_W-1:0];
      // NOTE: n_acc and found are running values updated with blocking assignments so
      // each younger lane sees what the older lanes already claimed.
      if (push_acc[i]) n_acc = n_acc + CNT_W'(1);
      if (push_req[i] && !push_acc[i]) drop = 1'b1;
      if (lane_ok[i] && mispred[i]) begin
        found      = 1'b1;
        win_target = next_pc[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= '0;
      out_link     <= '0;
      branch_flush <= 1'b0;
      flush_target <= '0;
      upd_drop     <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      out_valid    <= lane_ok;
      for (int i = 0; i < LANES; i++) out_link[i*32 +: 32] <= link[i];
      branch_flush <= found;
      if (found) flush_target <= win_target;
      upd_drop     <= drop;
      rd_ptr       <= rd_ptr + PTR_W'(pop);
      wr_ptr       <= wr_ptr + n_acc[PTR_W-1:0];
      count        <= count - CNT_W'(pop) + n_acc;
    end
  end

  // NOTE: record storage is not reset; count alone says which entries are live, and the
  // head fields are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_acc[i]) begin
        mem[slot[i]] <= '{pc: in_pc[i*32 +: 32], target: target[i], taken: taken[i], kind: kind[i]};
      end
    end
  end

  assign head       = mem[rd_ptr];
  assign upd_valid  = (count != '0);
  assign upd_pc     = upd_valid ? head.pc     : '0;
  assign upd_target = upd_valid ? head.target : '0;
  assign upd_taken  = upd_valid ? head.taken  : 1'b0;
  assign upd_kind   = upd_valid ? head.kind   : 2'd0;

endmodule

// File: tb/tb_branch_resolve_multi.sv
// Directed bench for branch_resolve_multi: vector table plus multi-cycle FIFO/flush sequences.
module tb_branch_resolve_multi;
  localparam int LANES = 2;
  localparam int DEPTH = 4;

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_BEQ  = 8'h50;
  localparam logic [7:0] OP_BNE  = 8'h51;
  localparam logic [7:0] OP_BLT  = 8'h52;
  localparam logic [7:0] OP_BGE  = 8'h53;
  localparam logic [7:0] OP_BLTU = 8'h54;
  localparam logic [7:0] OP_BGEU = 8'h55;
  localparam logic [7:0] OP_B    = 8'h56;
  localparam logic [7:0] OP_BL   = 8'h57;
  localparam logic [7:0] OP_JIRL = 8'h58;

  logic                clk = 1'b0;
  logic                rst, ex_flush, upd_ready;
  logic [LANES-1:0]    in_valid, in_pre_taken;
  logic [32*LANES-1:0] in_pc, in_inst, in_reg1, in_reg2, in_pre_addr;
  logic [8*LANES-1:0]  in_aluop;
  logic [LANES-1:0]    out_valid;
  logic [32*LANES-1:0] out_link;
  logic                branch_flush, upd_valid, upd_taken, upd_drop;
  logic [31:0]         flush_target, upd_pc, upd_target;
  logic [1:0]          upd_kind;

  branch_resolve_multi #(.LANES(LANES), .UPD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ex_flush(ex_flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_aluop(in_aluop),
    .in_reg1(in_reg1), .in_reg2(in_reg2), .in_pre_taken(in_pre_taken), .in_pre_addr(in_pre_addr),
    .out_valid(out_valid), .out_link(out_link), .branch_flush(branch_flush),
    .flush_target(flush_target), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken), .upd_kind(upd_kind),
    .upd_drop(upd_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk16(input int off);
    logic [31:0] w, r;
    w = off >>> 2;
    r = '0;
    r[25:10] = w[15:0];
    return r;
  endfunction

  function automatic logic [31:0] mk26(input int off);
    logic [31:0] w, r;
    w = off >>> 2;
    r = '0;
    r[25:10] = w[15:0];
    r[9:0]   = w[25:16];
    return r;
  endfunction

  task automatic clear_lanes();
    in_valid = '0; in_pc = '0; in_inst = '0; in_aluop = '0;
    in_reg1 = '0; in_reg2 = '0; in_pre_taken = '0; in_pre_addr = '0;
  endtask

  task automatic set_lane(input int ln, input logic [7:0] op, input logic [31:0] pc,
                          input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                          input logic pt, input logic [31:0] pa);
    in_valid[ln]          = 1'b1;
    in_aluop[ln*8 +: 8]   = op;
    in_pc[ln*32 +: 32]    = pc;
    in_inst[ln*32 +: 32]  = inst;
    in_reg1[ln*32 +: 32]  = r1;
    in_reg2[ln*32 +: 32]  = r2;
    in_pre_taken[ln]      = pt;
    in_pre_addr[ln*32 +: 32] = pa;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops everything with ready held high, bounded to 8 cycles.
  task automatic drain(output int n);
    n = 0;
    upd_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (upd_valid) n++;
      step();
    end
    upd_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [7:0]  op0;  logic [31:0] pc0, in0, a0, b0; logic pt0; logic [31:0] pa0;
    logic [7:0]  op1;  logic [31:0] pc1, in1, a1, b1; logic pt1; logic [31:0] pa1;
    logic [1:0]  ov;
    logic        fl;
    logic [31:0] ft;
    int          n;
    logic [31:0] rpc;
    logic        rtk;
    logic [31:0] rtg;
    logic [1:0]  rkd;
    logic        chk_tg;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] v,
      input logic [7:0] op0, input logic [31:0] pc0, input logic [31:0] in0,
      input logic [31:0] a0, input logic [31:0] b0, input logic pt0, input logic [31:0] pa0,
      input logic [7:0] op1, input logic [31:0] pc1, input logic [31:0] in1,
      input logic [31:0] a1, input logic [31:0] b1, input logic pt1, input logic [31:0] pa1,
      input logic [1:0] ov, input logic fl, input logic [31:0] ft, input int n,
      input logic [31:0] rpc, input logic rtk, input logic [31:0] rtg, input logic [1:0] rkd,
      input logic chk_tg);
    vec_t t;
    t.v = v;
    t.op0 = op0; t.pc0 = pc0; t.in0 = in0; t.a0 = a0; t.b0 = b0; t.pt0 = pt0; t.pa0 = pa0;
    t.op1 = op1; t.pc1 = pc1; t.in1 = in1; t.a1 = a1; t.b1 = b1; t.pt1 = pt1; t.pa1 = pa1;
    t.ov = ov; t.fl = fl; t.ft = ft; t.n = n;
    t.rpc = rpc; t.rtk = rtk; t.rtg = rtg; t.rkd = rkd; t.chk_tg = chk_tg;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [31:0] exp_pcs [4];

    rst = 1'b1; ex_flush = 1'b0; upd_ready = 1'b0;
    clear_lanes();
    repeat (2) step();
    check("rst out_valid", out_valid, 0);
    check("rst out_link", out_link[31:0] | out_link[63:32], 0);
    check("rst branch_flush", branch_flush, 0);
    check("rst flush_target", flush_target, 0);
    check("rst upd_valid", upd_valid, 0);
    check("rst upd_fields", upd_pc | upd_target | {29'd0, upd_taken, upd_kind}, 0);
    check("rst upd_drop", upd_drop, 0);
    rst = 1'b0;
    step();

    // v  | lane0: op pc inst r1 r2 pt pa | lane1: ... | exp: ov fl ft n | first record | chk_tg
    add_vec(2'b01, OP_BEQ, 32'h1C000000, mk16(16), 5, 5, 1, 32'h1C000010,
            OP_ADD, 0, 0, 0, 0, 0, 0,
            2'b01, 0, 0, 1, 32'h1C000000, 1, 32'h1C000010, 0, 1);
    add_vec(2'b01, OP_BLT, 32'h1C000100, mk16(32), 32'hFFFFFFFF, 1, 0, 0,
            OP_ADD, 0, 0, 0, 0, 0, 0,
            2'b01, 1, 32'h1C000120, 1, 32'h1C000100, 1, 32'h1C000120, 0, 1);
    add_vec(2'b01, OP_BLTU, 32'h1C000180, mk16(32), 32'hFFFFFFFF, 1, 0, 0,
            OP_ADD, 0, 0, 0, 0, 0, 0,
            2'b01, 0, 0, 1, 32'h1C000180, 0, 0, 0, 0);
    add_vec(2'b11, OP_ADD, 32'h1C000200, 0, 0, 0, 1, 32'h1C000400,
            OP_JIRL, 32'h1C000204, mk16(0), 32'h1C002000, 0, 1, 0,
            2'b01, 1, 32'h1C000204, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, OP_JIRL, 32'h1C000300, mk16(-4), 32'h1C001000, 0, 1, 32'h1C000000,
            OP_ADD, 0, 0, 0, 0, 0, 0,
            2'b01, 1, 32'h1C000FFC, 1, 32'h1C000300, 1, 32'h1C000FFC, 3, 1);
    add_vec(2'b11, OP_BL, 32'h1C000400, mk26(32'h100000), 0, 0, 1, 32'h1C100400,
            OP_BNE, 32'h1C000404, mk16(-8), 1, 2, 1, 32'h1C0003FC,
            2'b11, 0, 0, 1, 32'h1C000404, 1, 32'h1C0003FC, 0, 1);
    add_vec(2'b11, OP_B, 32'h1C000500, mk26(-32'h500), 0, 0, 0, 0,
            OP_BEQ, 32'h1C000504, mk16(8), 3, 3, 0, 0,
            2'b01, 1, 32'h1C000000, 1, 32'h1C000500, 1, 32'h1C000000, 1, 1);
    add_vec(2'b11, OP_BGE, 32'h1C000600, mk16(64), 1, 32'hFFFFFFFF, 1, 32'h1C000640,
            OP_BGEU, 32'h1C000604, mk16(64), 1, 32'hFFFFFFFF, 1, 32'h1C000644,
            2'b11, 1, 32'h1C000608, 2, 32'h1C000600, 1, 32'h1C000640, 0, 1);
    add_vec(2'b11, OP_ADD, 32'h1C000680, 0, 0, 0, 0, 0,
            OP_ADD, 32'h1C000684, 0, 0, 0, 0, 0,
            2'b11, 0, 0, 0, 0, 0, 0, 0, 0);
    add_vec(2'b01, OP_BNE, 32'h1C000700, mk16(16), 7, 7, 1, 32'h1C000710,
            OP_ADD, 0, 0, 0, 0, 0, 0,
            2'b01, 1, 32'h1C000704, 1, 32'h1C000700, 0, 0, 0, 0);
    add_vec(2'b01, OP_BL, 32'h1C000800, mk26(32'h800), 0, 0, 0, 0,
            OP_ADD, 0, 0, 0, 0, 0, 0,
            2'b01, 1, 32'h1C001000, 1, 32'h1C000800, 1, 32'h1C001000, 2, 1);

    for (int k = 0; k < vecs.size(); k++) begin
      vec_t t;
      t = vecs[k];
      clear_lanes();
      if (t.v[0]) set_lane(0, t.op0, t.pc0, t.in0, t.a0, t.b0, t.pt0, t.pa0);
      if (t.v[1]) set_lane(1, t.op1, t.pc1, t.in1, t.a1, t.b1, t.pt1, t.pa1);
      step();
      check($sformatf("v%0d out_valid", k), out_valid, t.ov);
      check($sformatf("v%0d out_link0", k), out_link[31:0], t.pc0 + 32'd4);
      if (t.v[1]) check($sformatf("v%0d out_link1", k), out_link[63:32], t.pc1 + 32'd4);
      check($sformatf("v%0d branch_flush", k), branch_flush, t.fl);
      if (t.fl) check($sformatf("v%0d flush_target", k), flush_target, t.ft);
      check($sformatf("v%0d upd_valid", k), upd_valid, t.n > 0);
      if (t.n > 0) begin
        check($sformatf("v%0d upd_pc", k), upd_pc, t.rpc);
        check($sformatf("v%0d upd_taken", k), upd_taken, t.rtk);
        check($sformatf("v%0d upd_kind", k), upd_kind, t.rkd);
        if (t.chk_tg) check($sformatf("v%0d upd_target", k), upd_target, t.rtg);
      end
      clear_lanes();
      drain(n);
      check($sformatf("v%0d records", k), n, t.n);
    end

    // Flush is a one-cycle pulse and inputs during it are ignored.
    clear_lanes();
    set_lane(0, OP_BLT, 32'h1C000900, mk16(16), 32'hFFFFFFFF, 1, 0, 0);
    step();
    check("pulse flush", branch_flush, 1);
    check("pulse target", flush_target, 32'h1C000910);
    clear_lanes();
    set_lane(0, OP_BEQ, 32'h1C000A00, mk16(16), 1, 1, 0, 0);
    step();
    check("pulse flush drops", branch_flush, 0);
    check("pulse ignored valid", out_valid, 0);
    clear_lanes();
    drain(n);
    check("pulse records", n, 1);

    // Overflow: 5 conditional pushes into 4 entries with ready low, then pop+push on full.
    clear_lanes();
    set_lane(0, OP_BEQ, 32'h1C001000, mk16(8), 1, 2, 0, 0);
    set_lane(1, OP_BEQ, 32'h1C001004, mk16(8), 1, 2, 0, 0);
    step();
    check("ovf c1 drop", upd_drop, 0);
    clear_lanes();
    set_lane(0, OP_BEQ, 32'h1C001008, mk16(8), 1, 2, 0, 0);
    set_lane(1, OP_BEQ, 32'h1C00100C, mk16(8), 1, 2, 0, 0);
    step();
    check("ovf c2 drop", upd_drop, 0);
    check("ovf head stable", upd_pc, 32'h1C001000);
    clear_lanes();
    set_lane(0, OP_BEQ, 32'h1C001010, mk16(8), 1, 2, 0, 0);
    step();
    check("ovf c3 drop", upd_drop, 1);
    check("ovf head kept", upd_pc, 32'h1C001000);
    clear_lanes();
    set_lane(0, OP_BEQ, 32'h1C001014, mk16(8), 1, 2, 0, 0);
    upd_ready = 1'b1;
    step();
    check("full pop+push drop", upd_drop, 0);
    clear_lanes();
    exp_pcs = '{32'h1C001004, 32'h1C001008, 32'h1C00100C, 32'h1C001014};
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (upd_valid) begin
        if (n < 4) check($sformatf("ovf pop%0d pc", n), upd_pc, exp_pcs[n]);
        n++;
      end
      step();
    end
    upd_ready = 1'b0;
    check("ovf remaining records", n, 4);

    // ex_flush cancels a coincident mispredict.
    clear_lanes();
    set_lane(0, OP_BLT, 32'h1C002000, mk16(16), 32'hFFFFFFFF, 1, 0, 0);
    ex_flush = 1'b1;
    step();
    check("exf branch_flush", branch_flush, 0);
    check("exf out_valid", out_valid, 0);
    check("exf upd_valid", upd_valid, 0);
    ex_flush = 1'b0;
    clear_lanes();
    step();
    check("exf no late flush", branch_flush, 0);

    // Reset with three queued records and a pending mispredict.
    set_lane(0, OP_BEQ, 32'h1C003000, mk16(8), 1, 2, 0, 0);
    set_lane(1, OP_BEQ, 32'h1C003004, mk16(8), 1, 2, 0, 0);
    step();
    clear_lanes();
    set_lane(0, OP_BEQ, 32'h1C003008, mk16(8), 1, 2, 0, 0);
    step();
    check("pre-rst upd_valid", upd_valid, 1);
    clear_lanes();
    set_lane(0, OP_BLT, 32'h1C003100, mk16(16), 32'hFFFFFFFF, 1, 0, 0);
    rst = 1'b1;
    step();
    check("mid-rst upd_valid", upd_valid, 0);
    check("mid-rst upd_pc", upd_pc, 0);
    check("mid-rst branch_flush", branch_flush, 0);
    check("mid-rst out_valid", out_valid, 0);
    rst = 1'b0;
    clear_lanes();
    step();
    check("post-rst upd_valid", upd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
